// File: rtl/shift_issue_stage_if.sv
// Handshake bundles around the shift issue stage: decode -> stage and stage -> shifter.
// Decode is the master of shift_dec_if; the issue stage is the master of shift_exe_if.
interface shift_dec_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_operand;
  logic [WIDTH-1:0] in_rt;
  logic [AMT_W-1:0] in_imm;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;

  modport master (
    output in_valid, in_operand, in_rt, in_imm, in_op, in_tag,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_operand, in_rt, in_imm, in_op, in_tag,
    output in_ready
  );
endinterface

interface shift_exe_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int TAG_W = 4
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] shift_string;
  logic [AMT_W-1:0] shift_amount;
  logic             left;
  logic [TAG_W-1:0] out_tag;
  logic             out_sat;

  modport master (
    output out_valid, shift_string, shift_amount, left, out_tag, out_sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, shift_string, shift_amount, left, out_tag, out_sat,
    output out_ready
  );
endinterface

// File: rtl/shift_issue_stage.sv
// Issue stage in front of the 16-bit shifter: resolves and saturates the shift amount,
// then holds up to two operations (main + skid) so the shifter always sees registered operands.
module shift_issue_stage #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4,
  parameter int TAG_W = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        flush,
  shift_dec_if.slave  dec,
  shift_exe_if.master exe,
  output logic [7:0]  sat_count
);

  typedef struct packed {
    logic [WIDTH-1:0] str;
    logic [AMT_W-1:0] amt;
    logic             left;
    logic [TAG_W-1:0] tag;
    logic             sat;
  } entry_t;

  // Encoding is {skid_valid, main_valid}; 2'b10 can never occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     new_entry;
  logic [7:0] sat_count_q, sat_count_d;
  logic       accept;
  logic       drain;

  assign dec.in_ready = ~state_q[1];
  assign exe.out_valid = state_q[0];
  assign accept = dec.in_valid & ~state_q[1];
  assign drain  = state_q[0] & exe.out_ready;

  // Out-of-range register amounts become a zero string shifted by zero, which gives
  // the architecturally required all-zero result without a wider shifter.
  always_comb begin
    new_entry      = '0;
    new_entry.left = dec.in_op[0];
    new_entry.tag  = dec.in_tag;
    if (dec.in_op[1]) begin
      new_entry.str = dec.in_operand;
      new_entry.amt = dec.in_imm;
    end else if (dec.in_rt[WIDTH-1:AMT_W] == '0) begin
      new_entry.str = dec.in_operand;
      new_entry.amt = dec.in_rt[AMT_W-1:0];
    end else begin
      new_entry.sat = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = new_entry;
        end
      end
      ONE: begin
        if (accept && !drain) begin
          state_d = FULL;
          skid_d  = new_entry;
        end else if (accept && drain) begin
          main_d = new_entry;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush squashes everything but leaves the entry contents as stale don't-care values.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (accept && new_entry.sat && (sat_count_q != 8'hFF)) begin
      sat_count_d = sat_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign exe.shift_string = main_q.str;
  assign exe.shift_amount = main_q.amt;
  assign exe.left         = main_q.left;
  assign exe.out_tag      = main_q.tag;
  assign exe.out_sat      = main_q.sat;
  assign sat_count        = sat_count_q;

endmodule
